// File: rtl/pb_preset_cycler.sv
// rtl/pb_preset_cycler.sv - push-button driven EQ preset stepper with load handshake and lockout
// Optional: `define PB_PRESET_ACK_TIMEOUT_EN adds the ack_err output and a 256-cycle REQ watchdog.
module pb_preset_cycler #(
  parameter int NUM_PRESETS = 4,
  parameter int LOCKOUT_CYC = 500000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           released,
  input  logic                           load_ack,
  output logic [$clog2(NUM_PRESETS)-1:0] preset,
  output logic                           load_req,
  output logic                           busy
`ifdef PB_PRESET_ACK_TIMEOUT_EN
  ,
  output logic                           ack_err
`endif
);

  localparam int PW = $clog2(NUM_PRESETS);
  localparam int CW = $clog2(LOCKOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   preset_nx;
  logic            load_req_nx;
  logic [CW-1:0]   cnt, cnt_nx;
`ifdef PB_PRESET_ACK_TIMEOUT_EN
  logic [7:0]      wd, wd_nx;
  logic            ack_err_nx;
`endif

  // State register plus all registered outputs; reset aborts any request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      preset   <= '0;
      load_req <= 1'b0;
      cnt      <= '0;
`ifdef PB_PRESET_ACK_TIMEOUT_EN
      wd       <= '0;
      ack_err  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      preset   <= preset_nx;
      load_req <= load_req_nx;
      cnt      <= cnt_nx;
`ifdef PB_PRESET_ACK_TIMEOUT_EN
      wd       <= wd_nx;
      ack_err  <= ack_err_nx;
`endif
    end
  end

  // Next-state logic: step preset on a pulse in IDLE, hold REQ until ack, then serve lockout
  always_comb begin
    state_nx    = state;
    preset_nx   = preset;
    load_req_nx = load_req;
    cnt_nx      = cnt;
`ifdef PB_PRESET_ACK_TIMEOUT_EN
    wd_nx       = wd;
    ack_err_nx  = ack_err;
`endif
    case (state)
      S_IDLE: begin
        load_req_nx = 1'b0;
        if (released) begin
          preset_nx   = (preset == PW'(NUM_PRESETS - 1)) ? '0 : preset + PW'(1);
          load_req_nx = 1'b1;
          state_nx    = S_REQ;
`ifdef PB_PRESET_ACK_TIMEOUT_EN
          wd_nx       = '0;
`endif
        end
      end
      S_REQ: begin
        load_req_nx = 1'b1;
        // An ack on the timeout edge is a normal exit, so it is tested first
        if (load_ack) begin
          load_req_nx = 1'b0;
          cnt_nx      = CW'(LOCKOUT_CYC - 1);
          state_nx    = S_LOCK;
        end
`ifdef PB_PRESET_ACK_TIMEOUT_EN
        else if (wd == 8'hFF) begin
          load_req_nx = 1'b0;
          ack_err_nx  = 1'b1;
          cnt_nx      = CW'(LOCKOUT_CYC - 1);
          state_nx    = S_LOCK;
        end else begin
          wd_nx = wd + 8'd1;
        end
`endif
      end
      S_LOCK: begin
        load_req_nx = 1'b0;
        if (cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        load_req_nx = 1'b0;
        state_nx    = S_IDLE;
      end
    endcase
  end

  // Output decode: busy reflects only the registered state
  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_pb_preset_cycler.sv
// tb/tb_pb_preset_cycler.sv - randomized self-checking bench for pb_preset_cycler
module tb_pb_preset_cycler;

  localparam int NP = 4;
  localparam int LC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       released = 1'b0;
  logic       load_ack = 1'b0;
  logic [1:0] preset;
  logic       load_req;
  logic       busy;
`ifdef PB_PRESET_ACK_TIMEOUT_EN
  logic       ack_err;
`endif

  pb_preset_cycler #(.NUM_PRESETS(NP), .LOCKOUT_CYC(LC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .released (released),
    .load_ack (load_ack),
    .preset   (preset),
    .load_req (load_req),
    .busy     (busy)
`ifdef PB_PRESET_ACK_TIMEOUT_EN
    ,
    .ack_err  (ack_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: preset value, an outstanding request flag, lockout cycles still owed,
  // number of REQ cycles already waited, and the sticky error flag.
  int m_preset = 0;
  bit m_req = 0;
  int m_left = 0;
  int m_wait = 0;
  bit m_err = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_preset = 0; m_req = 0; m_left = 0; m_wait = 0; m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".preset"}, int'(preset), m_preset);
    check_eq({tag, ".load_req"}, int'(load_req), int'(m_req));
    check_eq({tag, ".busy"}, int'(busy), int'(m_req || m_left > 0));
`ifdef PB_PRESET_ACK_TIMEOUT_EN
    check_eq({tag, ".ack_err"}, int'(ack_err), int'(m_err));
`endif
  endtask

  // Apply one cycle of inputs, advance the model on the edge, check just after it
  task automatic step(input bit rel, input bit ack, input string tag);
    released = rel;
    load_ack = ack;
    @(posedge clk);
    if (m_req) begin
      if (ack) begin
        m_req = 0; m_left = LC;
      end else begin
        m_wait = m_wait + 1;
`ifdef PB_PRESET_ACK_TIMEOUT_EN
        if (m_wait == 256) begin
          m_req = 0; m_left = LC; m_err = 1;
        end
`endif
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (rel) begin
      m_preset = (m_preset + 1) % NP;
      m_req = 1;
      m_wait = 0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic serve(input string tag);
    for (int i = 0; i < LC + 2; i++) step(1'b0, 1'b0, tag);
  endtask

  int cnt;

  initial begin
    // Reset state while rst_n is held low
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: pulse, ack two cycles later, then measure the lockout length
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "t1_idle");
    step(1'b1, 1'b0, "t1_pulse");
    check_eq("t1_preset1", int'(preset), 1);
    step(1'b0, 1'b0, "t1_req");
    step(1'b0, 1'b1, "t1_ack");
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      step(1'b0, 1'b0, "t1_lock");
    end
    check_eq("t1_lock_len", cnt, LC);

    // Test 2: walk through the remaining presets including the wrap to 0
    for (int k = 0; k < NP; k++) begin
      step(1'b1, 1'b0, "t2_pulse");
      step(1'b0, 1'b1, "t2_ack");
      serve("t2_lock");
    end
    check_eq("t2_wrap", int'(preset), 1);

    // Test 3/4: bounce during REQ, simultaneous release+ack, bounce through lockout
    step(1'b1, 1'b0, "t3_pulse");
    step(1'b1, 1'b0, "t3_req_bounce");
    step(1'b1, 1'b1, "t3_rel_ack");
    for (int i = 0; i < LC; i++) step(1'b1, 1'b0, "t3_lock_bounce");
    step(1'b1, 1'b0, "t3_first_idle");
    check_eq("t3_accept", int'(load_req), 1);
    step(1'b0, 1'b1, "t3_ack");
    serve("t3_lock");

    // Test 4: ack held high, request lasts one cycle per pulse
    load_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, "t4_pulse");
      step(1'b0, 1'b1, "t4_ack");
      check_eq("t4_req_width", int'(load_req), 0);
      for (int i = 0; i < LC; i++) step(1'b0, 1'b1, "t4_lock");
    end

    // Test 5: asynchronous reset mid-REQ with preset=2
    model_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step(1'b1, 1'b0, "t5_p1");
    step(1'b0, 1'b1, "t5_a1");
    serve("t5_l1");
    step(1'b1, 1'b0, "t5_p2");
    check_eq("t5_pre_preset", int'(preset), 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_async");
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b0, "t5_resume");
    step(1'b0, 1'b1, "t5_resume_ack");
    serve("t5_resume_lock");

`ifdef PB_PRESET_ACK_TIMEOUT_EN
    // Test 6a: no ack for 256 REQ cycles -> timeout and sticky error
    step(1'b1, 1'b0, "t6_pulse");
    for (int i = 0; i < 256; i++) step(1'b0, 1'b0, "t6_wait");
    check_eq("t6_err", int'(ack_err), 1);
    serve("t6_lock");
    // Test 6b: after reset, ack on exactly the 256th REQ cycle keeps ack_err low
    model_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step(1'b1, 1'b0, "t6b_pulse");
    for (int i = 0; i < 255; i++) step(1'b0, 1'b0, "t6b_wait");
    step(1'b0, 1'b1, "t6b_ack");
    check_eq("t6b_err", int'(ack_err), 0);
    serve("t6b_lock");
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pb_preset_cycler.md
Name: pb_preset_cycler

Overview:
Consumes the one-cycle `released` pulse from the push-button release detector and steps the equalizer through NUM_PRESETS gain presets, wrapping at the top. Each step raises a request/acknowledge handshake toward the gain-coefficient loader. A post-load lockout window rejects residual button bounce. Sits between the button release detector and the EQ gain loader.

Parameters:
NUM_PRESETS, 4, number of presets; legal values 2 or more; preset index wraps at NUM_PRESETS-1.
LOCKOUT_CYC, 500000, clock cycles spent in LOCKOUT after each acknowledged load; legal values 1 or more; 500000 is 10 ms at 50 MHz.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
released  input  1  one-cycle pulse from the release detector, synchronous to clk.
load_ack  input  1  loader acknowledge; sampled only in REQ.
preset  output  $clog2(NUM_PRESETS)  current preset index, registered.
load_req  output  1  load request to the gain loader, registered.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE, preset = 0, load_req = 0, busy = 0, lockout counter = 0.
  - Reset asserted mid-REQ or mid-LOCKOUT aborts the operation immediately. No request survives reset.
- State machine:
  - IDLE:
    - released=1 at edge k: preset <= (preset == NUM_PRESETS-1) ? 0 : preset+1; state <= REQ; load_req <= 1.
    - New preset and load_req are both visible after edge k, i.e. one-cycle latency from the pulse.
  - REQ:
    - load_req stays high and preset stays stable until load_ack=1 is sampled.
    - On that edge: load_req <= 0; counter <= LOCKOUT_CYC-1; state <= LOCKOUT.
    - load_ack high in the first cycle load_req is high is accepted. No minimum request width.
  - LOCKOUT:
    - Counter decrements each cycle.
    - At counter == 0: state <= IDLE.
    - Total time in LOCKOUT is exactly LOCKOUT_CYC cycles.
- Dropped and ignored inputs:
  - released pulses in REQ or LOCKOUT are discarded, not queued.
  - A pulse in the first IDLE cycle after LOCKOUT is accepted.
  - load_ack in IDLE or LOCKOUT is ignored.
- Counter width: $clog2(LOCKOUT_CYC+1) bits, unsigned, no wrap. The counter is only loaded on the REQ->LOCKOUT transition.
- busy is a combinational decode of the registered state: busy = (state != IDLE). No other output is combinational from an input.
- Simultaneous events: released and load_ack both high while in REQ: ack is honoured, released is dropped.
- Unreachable state encodings recover to IDLE on the next edge with load_req=0.

Optional Feature:
Macro PB_PRESET_ACK_TIMEOUT_EN.
- Defined:
  - Adds output port ack_err (1 bit, reset 0) and an 8-bit REQ watchdog.
  - Watchdog clears on REQ entry and increments each REQ cycle.
  - If 256 REQ cycles elapse without load_ack: load_req <= 0; ack_err <= 1 (sticky until reset); state <= LOCKOUT with the normal counter load.
  - preset keeps the new value.
  - An ack arriving on the same edge as the timeout wins: it is a normal exit and ack_err is unchanged.
- Not defined: no ack_err port, no watchdog; REQ waits indefinitely for load_ack.

Test Plan:
1. Reset release, then NUM_PRESETS=4, LOCKOUT_CYC=8, released pulse at cycle 5 -> preset=1, load_req=1, busy=1 after edge 5. load_ack at cycle 7 -> load_req=0 after edge 7. busy=1 for exactly 8 more cycles, then 0.
2. Four pulse/ack sequences, each with its lockout served -> preset 1,2,3,0 (wrap from 3 to 0 verified).
3. Bounce rejection: pulses at REQ+1 and at each of LOCKOUT cycles 1..8 -> preset unchanged, no extra load_req. Pulse on the first IDLE cycle -> accepted, preset increments.
4. Same-cycle ack: load_ack held at 1 continuously -> load_req high for exactly 1 cycle per pulse. Released and ack together in REQ -> single increment only.
5. rst_n dropped asynchronously mid-REQ (preset=2, load_req=1) -> preset=0, load_req=0, busy=0 without waiting for a clock edge. Normal operation resumes after reset is released.
6. With PB_PRESET_ACK_TIMEOUT_EN defined:
   - No ack for 256 REQ cycles -> load_req falls, ack_err=1 (sticky), LOCKOUT of 8 cycles.
   - Ack on cycle 256 exactly -> ack_err stays 0.
